branch_update_queue: RTL and testbench

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

---
 rtl/branch_update_queue_if.sv | 34 +++
 rtl/branch_update_queue.sv | 128 ++++++++++++
 tb/tb_branch_update_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/branch_update_queue_if.sv
// Handshake bundle between the branch pipeline and the update queue.
// The master drives push/resolve/flush and the slave returns update strobes and occupancy.
interface branch_update_queue_if #(
    parameter int IWIDTH = 6,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              en;
    logic              push;
    logic [IWIDTH-1:0] push_index;
    logic              push_pred;
    logic              resolve;
    logic              resolve_taken;
    logic              flush;
    logic              do_update;
    logic              last_taken;
    logic [IWIDTH-1:0] upd_index;
    logic              mispredict;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              error;

    modport master (
        output en, push, push_index, push_pred, resolve, resolve_taken, flush,
        input  do_update, last_taken, upd_index, mispredict, full, empty, count, error
    );

    modport slave (
        input  en, push, push_index, push_pred, resolve, resolve_taken, flush,
        output do_update, last_taken, upd_index, mispredict, full, empty, count, error
    );
endinterface

// File: rtl/branch_update_queue.sv
// In-flight branch queue: holds {index, pred} per predicted branch, pops on resolve and
// emits a one-cycle registered update strobe; mispredicts squash the younger wrong-path entries.
module branch_update_queue #(
    parameter int IWIDTH = 6,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_update_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IWIDTH-1:0] r_idx_mem  [DEPTH];
    logic              r_pred_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_do_update;
    logic              r_last_taken;
    logic [IWIDTH-1:0] r_upd_index;
    logic              r_mispredict;
    logic              r_error;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_mispred;
    logic              w_squash;
    logic              w_push_ok;
    logic              w_push_drop;
    logic              w_resolve_bad;
    logic [CW-1:0]     w_count_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});

    // Decode this cycle's pop/push/squash; everything is qualified by the global advance.
    always_comb begin
        w_pop         = 1'b0;
        w_mispred     = 1'b0;
        w_squash      = 1'b0;
        w_push_ok     = 1'b0;
        w_push_drop   = 1'b0;
        w_resolve_bad = 1'b0;
        w_count_nxt   = r_count;
        if (bus.en) begin
            w_pop         = bus.resolve & ~w_empty;
            w_resolve_bad = bus.resolve & w_empty;
            w_mispred     = w_pop & (r_pred_mem[r_head] != bus.resolve_taken);
            w_squash      = w_mispred | bus.flush;
            // A pop frees a slot at the same edge, so a full queue still accepts a push.
            w_push_drop   = bus.push & w_full & ~w_pop;
            w_push_ok     = bus.push & ~w_push_drop & ~w_squash;
            if (w_squash) begin
                w_count_nxt = {CW{1'b0}};
            end else begin
                w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push_ok}
                                      - {{(CW-1){1'b0}}, w_pop};
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Entry storage and queue pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_idx_mem[i]  <= {IWIDTH{1'b0}};
                r_pred_mem[i] <= 1'b0;
            end
        end else if (bus.en) begin
            r_count <= w_count_nxt;
            if (w_squash) begin
                r_head <= {PW{1'b0}};
                r_tail <= {PW{1'b0}};
            end else begin
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                if (w_push_ok) begin
                    r_idx_mem[r_tail]  <= bus.push_index;
                    r_pred_mem[r_tail] <= bus.push_pred;
                    r_tail             <= r_tail + PW'(1);
                end
            end
        end
    end

    // Registered update strobe; index/direction hold between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_do_update  <= 1'b0;
            r_last_taken <= 1'b0;
            r_upd_index  <= {IWIDTH{1'b0}};
            r_mispredict <= 1'b0;
        end else if (bus.en) begin
            r_do_update  <= w_pop;
            r_mispredict <= w_mispred;
            if (w_pop) begin
                r_last_taken <= bus.resolve_taken;
                r_upd_index  <= r_idx_mem[r_head];
            end
        end
    end

    // Sticky protocol error: overflow push or resolve with nothing in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (bus.en && (w_push_drop || w_resolve_bad)) begin
            r_error <= 1'b1;
        end
    end

    assign bus.do_update  = r_do_update;
    assign bus.last_taken = r_last_taken;
    assign bus.upd_index  = r_upd_index;
    assign bus.mispredict = r_mispredict;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue (IWIDTH=6, DEPTH=4) with hand-computed expectations.
module tb_branch_update_queue;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    branch_update_queue_if #(.IWIDTH(6), .DEPTH(4)) bus ();

    branch_update_queue #(.IWIDTH(6), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.en            = 1'b1;
        bus.push          = 1'b0;
        bus.push_index    = 6'd0;
        bus.push_pred     = 1'b0;
        bus.resolve       = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [5:0] idx, input logic pred);
        idle();
        bus.push = 1'b1; bus.push_index = idx; bus.push_pred = pred;
        cyc();
    endtask

    task automatic do_resolve(input logic taken);
        idle();
        bus.resolve = 1'b1; bus.resolve_taken = taken;
        cyc();
    endtask

    task automatic check_upd(input string tag, input logic [5:0] idx, input logic taken, input logic mis);
        check_eq({tag, ".do_update"}, {31'd0, bus.do_update}, 32'd1);
        check_eq({tag, ".upd_index"}, {26'd0, bus.upd_index}, {26'd0, idx});
        check_eq({tag, ".last_taken"}, {31'd0, bus.last_taken}, {31'd0, taken});
        check_eq({tag, ".mispredict"}, {31'd0, bus.mispredict}, {31'd0, mis});
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check_eq({tag, ".count"}, {29'd0, bus.count}, 32'd0);
        check_eq({tag, ".do_update"}, {31'd0, bus.do_update}, 32'd0);
        check_eq({tag, ".upd_index"}, {26'd0, bus.upd_index}, 32'd0);
        check_eq({tag, ".last_taken"}, {31'd0, bus.last_taken}, 32'd0);
        check_eq({tag, ".mispredict"}, {31'd0, bus.mispredict}, 32'd0);
        check_eq({tag, ".error"}, {31'd0, bus.error}, 32'd0);
        check_eq({tag, ".empty"}, {31'd0, bus.empty}, 32'd1);
        check_eq({tag, ".full"}, {31'd0, bus.full}, 32'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        reset = 1'b0;
        #2;
        pulse_reset("rst0");
        cyc();

        // Single push then correct resolve.
        do_push(6'd5, 1'b1);
        do_resolve(1'b1);
        check_upd("t1", 6'd5, 1'b1, 1'b0);
        check_eq("t1.empty", {31'd0, bus.empty}, 32'd1);
        idle(); cyc();
        check_eq("t1.strobe_drop", {31'd0, bus.do_update}, 32'd0);
        check_eq("t1.idx_hold", {26'd0, bus.upd_index}, 32'd5);

        // Mispredict squashes younger entries; resolve on empty then errors.
        do_push(6'd1, 1'b0);
        do_push(6'd2, 1'b0);
        do_push(6'd3, 1'b0);
        check_eq("t2.count3", {29'd0, bus.count}, 32'd3);
        do_resolve(1'b1);
        check_upd("t2", 6'd1, 1'b1, 1'b1);
        check_eq("t2.count0", {29'd0, bus.count}, 32'd0);
        check_eq("t2.err_pre", {31'd0, bus.error}, 32'd0);
        do_resolve(1'b1);
        check_eq("t2.error", {31'd0, bus.error}, 32'd1);
        check_eq("t2.no_upd", {31'd0, bus.do_update}, 32'd0);
        pulse_reset("rst1");

        // Fill, then push+pop while full; wrap-around order.
        for (int i = 0; i < 4; i++) do_push(6'(10 + i), 1'b0);
        check_eq("t3.full", {31'd0, bus.full}, 32'd1);
        idle();
        bus.push = 1'b1; bus.push_index = 6'd14; bus.push_pred = 1'b1;
        bus.resolve = 1'b1; bus.resolve_taken = 1'b0;
        cyc();
        check_upd("t3.pp", 6'd10, 1'b0, 1'b0);
        check_eq("t3.count4", {29'd0, bus.count}, 32'd4);
        check_eq("t3.full2", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_resolve(1'b0);
            check_eq("t3.order", {26'd0, bus.upd_index}, 32'(11 + i));
            check_eq("t3.mis", {31'd0, bus.mispredict}, 32'd0);
        end
        do_resolve(1'b1);
        check_upd("t3.wrap", 6'd14, 1'b1, 1'b0);
        check_eq("t3.empty", {31'd0, bus.empty}, 32'd1);
        check_eq("t3.noerr", {31'd0, bus.error}, 32'd0);

        // Overflow push is dropped and error stays sticky.
        for (int i = 0; i < 4; i++) do_push(6'(20 + i), 1'b1);
        do_push(6'd24, 1'b1);
        check_eq("t4.count", {29'd0, bus.count}, 32'd4);
        check_eq("t4.error", {31'd0, bus.error}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_resolve(1'b1);
            check_eq("t4.order", {26'd0, bus.upd_index}, 32'(20 + i));
        end
        check_eq("t4.empty", {31'd0, bus.empty}, 32'd1);
        idle(); cyc();
        check_eq("t4.sticky", {31'd0, bus.error}, 32'd1);
        pulse_reset("rst2");

        // Resolve held with en=0 produces exactly one pulse once enabled.
        do_push(6'd7, 1'b0);
        idle();
        bus.en = 1'b0; bus.resolve = 1'b1; bus.resolve_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("t5.held", {31'd0, bus.do_update}, 32'd0);
            check_eq("t5.cnt", {29'd0, bus.count}, 32'd1);
        end
        bus.en = 1'b1;
        cyc();
        check_upd("t5", 6'd7, 1'b0, 1'b0);
        bus.en = 1'b0;
        cyc();
        check_eq("t5.en0_hold", {31'd0, bus.do_update}, 32'd1);
        idle(); cyc();
        check_eq("t5.one_pulse", {31'd0, bus.do_update}, 32'd0);

        // Flush with a correct resolve pops head first; push is discarded.
        do_push(6'd30, 1'b1);
        do_push(6'd31, 1'b0);
        idle();
        bus.flush = 1'b1; bus.resolve = 1'b1; bus.resolve_taken = 1'b1;
        bus.push = 1'b1; bus.push_index = 6'd32; bus.push_pred = 1'b0;
        cyc();
        check_upd("t6.flush", 6'd30, 1'b1, 1'b0);
        check_eq("t6.count0", {29'd0, bus.count}, 32'd0);
        check_eq("t6.noerr", {31'd0, bus.error}, 32'd0);

        // Reset mid-stream discards in-flight entries.
        do_push(6'd33, 1'b1);
        do_push(6'd34, 1'b1);
        do_resolve(1'b1);
        check_eq("t7.pre", {26'd0, bus.upd_index}, 32'd33);
        pulse_reset("rst3");
        do_resolve(1'b1);
        check_eq("t7.no_upd", {31'd0, bus.do_update}, 32'd0);
        check_eq("t7.err", {31'd0, bus.error}, 32'd1);

        // Push + resolve on empty: resolve ignored, push kept.
        pulse_reset("rst4");
        idle();
        bus.push = 1'b1; bus.push_index = 6'd40; bus.push_pred = 1'b1;
        bus.resolve = 1'b1; bus.resolve_taken = 1'b1;
        cyc();
        check_eq("t8.count", {29'd0, bus.count}, 32'd1);
        check_eq("t8.err", {31'd0, bus.error}, 32'd1);
        check_eq("t8.no_upd", {31'd0, bus.do_update}, 32'd0);
        do_resolve(1'b1);
        check_upd("t8", 6'd40, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
